// File: rtl/vga_timing.sv
// +--------------------------------------------------------------------------+
// | vga_timing: 800x600@60 pixel/line counters with registered sync/blank.    |
// | Option macro VGA_TIMING_FRAME_CNT_EN adds sof and frame_cnt.  Rev 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

package vga_pkg;
  localparam int unsigned c_hor_total_time  = 1056;
  localparam int unsigned c_hor_blank_start = 800;
  localparam int unsigned c_hor_sync_start  = 840;
  localparam int unsigned c_hor_sync_end    = 968;
  localparam int unsigned c_ver_total_time  = 628;
  localparam int unsigned c_ver_blank_start = 600;
  localparam int unsigned c_ver_sync_start  = 601;
  localparam int unsigned c_ver_sync_end    = 605;
endpackage

module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned HOR_TOTAL_TIME  = c_hor_total_time,
  parameter int unsigned HOR_BLANK_START = c_hor_blank_start,
  parameter int unsigned HOR_SYNC_START  = c_hor_sync_start,
  parameter int unsigned HOR_SYNC_END    = c_hor_sync_end,
  parameter int unsigned VER_TOTAL_TIME  = c_ver_total_time,
  parameter int unsigned VER_BLANK_START = c_ver_blank_start,
  parameter int unsigned VER_SYNC_START  = c_ver_sync_start,
  parameter int unsigned VER_SYNC_END    = c_ver_sync_end
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        hblnk,
  output logic        vblnk
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic        sof,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [10:0] c_h_last = 11'(HOR_TOTAL_TIME - 1);
  localparam logic [10:0] c_v_last = 11'(VER_TOTAL_TIME - 1);
  localparam logic [10:0] c_hbs    = 11'(HOR_BLANK_START);
  localparam logic [10:0] c_hss    = 11'(HOR_SYNC_START);
  localparam logic [10:0] c_hse    = 11'(HOR_SYNC_END);
  localparam logic [10:0] c_vbs    = 11'(VER_BLANK_START);
  localparam logic [10:0] c_vss    = 11'(VER_SYNC_START);
  localparam logic [10:0] c_vse    = 11'(VER_SYNC_END);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        h_wrap_d;
  logic        frame_wrap_d;

  // Flags are derived from the next counter values so they land in the same
  // register stage as the counters they describe.
  always_comb begin
    h_wrap_d     = (hcount_q == c_h_last);
    frame_wrap_d = h_wrap_d && (vcount_q == c_v_last);
    hcount_d     = h_wrap_d ? 11'd0 : hcount_q + 11'd1;
    vcount_d     = vcount_q;
    if (h_wrap_d) begin
      vcount_d = frame_wrap_d ? 11'd0 : vcount_q + 11'd1;
    end
    hblnk_d = (hcount_d >= c_hbs);
    hsync_d = (hcount_d >= c_hss) && (hcount_d < c_hse);
    vblnk_d = (vcount_d >= c_vbs);
    vsync_d = (vcount_d >= c_vss) && (vcount_d < c_vse);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q <= 11'd0;
      vcount_q <= 11'd0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      hblnk_q  <= hblnk_d;
      vblnk_q  <= vblnk_d;
    end
  end

  assign hcount = hcount_q;
  assign vcount = vcount_q;
  assign hsync  = hsync_q;
  assign vsync  = vsync_q;
  assign hblnk  = hblnk_q;
  assign vblnk  = vblnk_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic        sof_q;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_wrap_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  // sof marks only a (0,0) reached by wrapping, never the post-reset (0,0).
  always_ff @(posedge clk) begin
    if (rst) begin
      sof_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      sof_q       <= frame_wrap_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sof       = sof_q;
  assign frame_cnt = frame_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: full horizontal timing, shortened frame height.
`default_nettype none

module tb_vga_timing;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount, vcount;
  logic        hsync, vsync, hblnk, vblnk;
  logic        act_sof;
  logic [15:0] act_fc;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic        sof;
  logic [15:0] frame_cnt;
  assign act_sof = sof;
  assign act_fc  = frame_cnt;
  localparam bit FC = 1'b1;
`else
  assign act_sof = 1'b0;
  assign act_fc  = 16'd0;
  localparam bit FC = 1'b0;
`endif

  vga_timing #(
    .HOR_TOTAL_TIME (1056),
    .HOR_BLANK_START(800),
    .HOR_SYNC_START (840),
    .HOR_SYNC_END   (968),
    .VER_TOTAL_TIME (16),
    .VER_BLANK_START(10),
    .VER_SYNC_START (11),
    .VER_SYNC_END   (14)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .hcount   (hcount),
    .vcount   (vcount),
    .hsync    (hsync),
    .vsync    (vsync),
    .hblnk    (hblnk),
    .vblnk    (vblnk)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .sof      (sof),
    .frame_cnt(frame_cnt)
`endif
  );

  typedef struct {
    int          t;
    string       name;
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb;
    bit          chkf;
    logic        sof;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   errors  = 0;
  int   checks  = 0;
  int   sof_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int t, input string name, input int h, input int v,
                      input bit hs, input bit vs, input bit hb, input bit vb,
                      input bit s, input int fc);
    exp_t e;
    e.t    = t;
    e.name = name;
    e.h    = 11'(h);
    e.v    = 11'(v);
    e.hs   = hs;
    e.vs   = vs;
    e.hb   = hb;
    e.vb   = vb;
    e.chkf = FC;
    e.sof  = s;
    e.fc   = 16'(fc);
    q.push_back(e);
  endtask

  task automatic wait_until(input int x);
    while (cyc < x) @(negedge clk);
  endtask

  // Monitor: every cycle presents outputs; compare whatever is due now.
  always @(negedge clk) begin
    exp_t e;
    if (act_sof === 1'b1) sof_cnt++;
    while (q.size() > 0 && q[0].t <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.t < cyc) begin
        errors++;
        $display("FAIL %s: not sampled at cycle %0d (now %0d)", e.name, e.t, cyc);
      end else if ({hcount, vcount, hsync, vsync, hblnk, vblnk} !== {e.h, e.v, e.hs, e.vs, e.hb, e.vb}
                   || (e.chkf && {act_sof, act_fc} !== {e.sof, e.fc})) begin
        errors++;
        $display("FAIL %s @%0d: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b sof=%b fc=%0d, expected h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b sof=%b fc=%0d",
                 e.name, cyc, hcount, vcount, hsync, vsync, hblnk, vblnk, act_sof, act_fc,
                 e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.sof, e.fc);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    b0 = cyc + 1;
    //      t            name          h     v   hs vs hb vb sof fc
    push(b0 + 0,     "reset_state",    0,    0,  0, 0, 0, 0, 0, 0);
    push(b0 + 1,     "release_1",      1,    0,  0, 0, 0, 0, 0, 0);
    push(b0 + 2,     "release_2",      2,    0,  0, 0, 0, 0, 0, 0);
    push(b0 + 3,     "release_3",      3,    0,  0, 0, 0, 0, 0, 0);
    push(b0 + 799,   "pre_hblank",     799,  0,  0, 0, 0, 0, 0, 0);
    push(b0 + 800,   "hblank_rise",    800,  0,  0, 0, 1, 0, 0, 0);
    push(b0 + 839,   "pre_hsync",      839,  0,  0, 0, 1, 0, 0, 0);
    push(b0 + 840,   "hsync_rise",     840,  0,  1, 0, 1, 0, 0, 0);
    push(b0 + 967,   "hsync_last",     967,  0,  1, 0, 1, 0, 0, 0);
    push(b0 + 968,   "hsync_fall",     968,  0,  0, 0, 1, 0, 0, 0);
    push(b0 + 1055,  "line_end",       1055, 0,  0, 0, 1, 0, 0, 0);
    push(b0 + 1056,  "line_wrap",      0,    1,  0, 0, 0, 0, 0, 0);
    push(b0 + 6335,  "line5_end",      1055, 5,  0, 0, 1, 0, 0, 0);
    push(b0 + 6336,  "line6_start",    0,    6,  0, 0, 0, 0, 0, 0);
    push(b0 + 9509,  "pre_vblank",     5,    9,  0, 0, 0, 0, 0, 0);
    push(b0 + 10560, "vblank_rise",    0,    10, 0, 0, 0, 1, 0, 0);
    push(b0 + 11615, "pre_vsync",      1055, 10, 0, 0, 1, 1, 0, 0);
    push(b0 + 11616, "vsync_rise",     0,    11, 0, 1, 0, 1, 0, 0);
    push(b0 + 14783, "vsync_last",     1055, 13, 0, 1, 1, 1, 0, 0);
    push(b0 + 14784, "vsync_fall",     0,    14, 0, 0, 0, 1, 0, 0);
    push(b0 + 16895, "frame_end",      1055, 15, 0, 0, 1, 1, 0, 0);
    push(b0 + 16896, "frame_wrap",     0,    0,  0, 0, 0, 0, 1, 1);
    push(b0 + 16897, "after_sof",      1,    0,  0, 0, 0, 0, 0, 1);
    push(b0 + 33791, "frame2_end",     1055, 15, 0, 0, 1, 1, 0, 1);
    push(b0 + 33792, "frame2_wrap",    0,    0,  0, 0, 0, 0, 1, 2);
    push(b0 + 33793, "after_sof2",     1,    0,  0, 0, 0, 0, 0, 2);
    @(negedge clk);
    rst = 1'b0;

    wait_until(b0 + 44851);
`ifdef VGA_TIMING_FRAME_CNT_EN
    checks++;
    if (sof_cnt != 2) begin
      errors++;
      $display("FAIL sof_pulse_count: got %0d, expected 2", sof_cnt);
    end
`endif
    push(b0 + 44852, "midframe_pos",   500,  10, 0, 0, 0, 1, 0, 2);
    push(b0 + 44853, "midframe_reset", 0,    0,  0, 0, 0, 0, 0, 0);
    push(b0 + 44854, "resume_1",       1,    0,  0, 0, 0, 0, 0, 0);
    push(b0 + 44855, "resume_2",       2,    0,  0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    b1 = b0 + 44853;

    wait_until(b1 + 100);
    push(b1 + 101,   "fc_preload",     101,  0,  0, 0, 0, 0, 0, 65535);
    push(b1 + 16895, "fc_pre_wrap",    1055, 15, 0, 0, 1, 1, 0, 65535);
    push(b1 + 16896, "fc_wrap",        0,    0,  0, 0, 0, 0, 1, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    force dut.frame_cnt_d = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.frame_cnt_d;
`endif

    wait_until(b1 + 16900);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
